load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Parametrised successor to the M-stage load extender. Accepts one load request per transaction from the M stage and issues a word-aligned read on the data bus using a valid/ready handshake. It then waits for the read response, extracts and sign- or zero-extends the addressed lane, and holds the result until the W stage accepts it.
- Supports byte, half, word and (at DATA_W=64) dword loads, a tag passthrough, misaligned-address detection and pipeline flush.

Parameters:
- DATA_W, 32, bus/result width; legal values 32 or 64. LANE_W = log2(DATA_W/8).
- ADDR_W, 32, byte-address width.
- TAG_W, 5, opaque tag (destination register) carried from request to response.

Ports:
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  kill the in-flight load (exception/eret)
- req_valid  input  1  M stage presents a load
- req_ready  output  1  unit can accept a request
- req_addr  input  ADDR_W  byte address
- req_op  input  4  [3]=unsigned, [2] reserved (ignored), [1:0] size: 00 byte, 01 half, 10 word, 11 dword
- req_tag  input  TAG_W  tag
- bus_rd_valid  output  1  read command valid
- bus_rd_addr  output  ADDR_W  req_addr with low LANE_W bits cleared
- bus_rd_ready  input  1  bus accepts command
- bus_rsp_valid  input  1  read data valid; bus never back-pressured
- bus_rsp_data  input  DATA_W  read data, little-endian lanes
- rsp_valid  output  1  result valid
- rsp_ready  input  1  W stage accepts result
- rsp_data  output  DATA_W  extended result
- rsp_tag  output  TAG_W  tag of the result
- rsp_exc  output  1  address-error (AdEL) flag; rsp_data is 0 when set

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- Reset (async, reset_n=0): state=IDLE. bus_rd_valid=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_exc=0. req_ready=1 after reset.
- req_ready=1 only in IDLE.
- IDLE:
  - On req_valid: capture addr, op and tag.
  - Aligned request: go to ISSUE.
  - Misaligned request (see Optional Feature): go directly to HOLD with rsp_exc=1.
- ISSUE: bus_rd_valid=1 with bus_rd_addr stable. On bus_rd_ready go to WAIT; if bus_rsp_valid arrives in the same cycle, go straight to HOLD.
- WAIT: on bus_rsp_valid, register the extracted result and go to HOLD. Minimum latency from request to rsp_valid is 2 cycles.
- HOLD: rsp_valid=1; rsp_data, rsp_tag and rsp_exc are stable. On rsp_ready go to IDLE. A new request is not accepted in the same cycle (no bypass).
- Extraction, with o = addr[LANE_W-1:0]:
  - byte: lane bus_rsp_data[8o+7:8o].
  - half: lane at 16·o[LANE_W-1:1].
  - word: lane at 32·o[LANE_W-1:2]; word at DATA_W=32 returns the whole bus.
  - dword: whole bus.
- Extension: unsigned=1 zero-extends to DATA_W, else sign-extends from the lane MSB. Word ops at DATA_W=32 ignore the unsigned bit.
- dword at DATA_W=32 is an illegal op: treated as misaligned (exception).
- Flush:
  - In ISSUE before handshake: drop, go to IDLE.
  - In ISSUE with handshake in the same cycle, or in WAIT: go to DRAIN. DRAIN discards the next bus_rsp_valid, then goes to IDLE; req_ready=0 while in DRAIN.
  - In HOLD: rsp_valid drops next cycle, go to IDLE.
  - Flush has priority over every other transition.
  - In IDLE, flush with req_valid in the same cycle: request ignored.
- Reset mid-transaction: state returns to IDLE immediately. The outstanding bus response is the interconnect's problem and is also reset.

Optional Feature:
- Macro LOAD_ALIGN_MISALIGN_EXC_EN.
- Defined: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0, or an illegal op produces no bus transaction. The unit goes IDLE→HOLD with rsp_exc=1, rsp_data=0 and rsp_tag captured.
- Undefined: rsp_exc is tied to 0. The offset is rounded down to the natural alignment of the size and the access proceeds normally. An illegal dword at DATA_W=32 behaves as word.

Test Plan:
- DATA_W=32, addr=0x1003, op=byte signed, bus returns 0x80FF_0000 -> rsp_data=0xFFFF_FF80, rsp_exc=0, rsp_tag echoed; rsp_valid exactly 2 cycles after accept with bus_rd_ready=1 and the response the next cycle.
- DATA_W=32, addr=0x2002, op=half unsigned, data 0x9ABC_1234 -> rsp_data=0x0000_9ABC. Hold rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0.
- DATA_W=64, addr=0x4, op=word signed, data 0x8000_0001_0000_0000 -> rsp_data=0xFFFF_FFFF_8000_0001. Same access as dword -> full data returned.
- Macro defined, addr=0x1001, op=word -> no bus_rd_valid pulse, rsp_exc=1, rsp_data=0. Macro undefined -> bus_rd_addr=0x1000, word returned unmodified.
- Flush in WAIT, then bus_rsp_valid 2 cycles later -> no rsp_valid, req_ready=0 until the response is drained, then 1.
- reset_n low while in HOLD -> rsp_valid=0 and req_ready=1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/load_align_unit.sv
// Load align unit: takes an M-stage load, issues a word-aligned bus read, then extracts and extends the addressed lane for W.
// Optional feature: define LOAD_ALIGN_MISALIGN_EXC_EN to raise AdEL on misaligned or illegal loads instead of rounding down.
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              bus_rd_valid,
    output logic [ADDR_W-1:0] bus_rd_addr,
    input  logic              bus_rd_ready,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_exc
);
    localparam int LANE_W = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;
    logic              req_fire, rsp_take, misaligned;
    logic [LANE_W-1:0] lane_off;
    logic [DATA_W-1:0] lane_shifted, lane_mask, lane_ext;
    logic              lane_sign;
    logic              unused_op;

    assign unused_op = req_op[2];

    // Byte-offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [LANE_W-1:0] size_mask(input logic [1:0] size);
        size_mask = LANE_W'((1 << size) - 1);
    endfunction

`ifdef LOAD_ALIGN_MISALIGN_EXC_EN
    always_comb begin
        misaligned = (req_addr[LANE_W-1:0] & size_mask(req_op[1:0])) != '0;
        if (DATA_W == 32 && req_op[1:0] == 2'b11) misaligned = 1'b1;
    end
`else
    assign misaligned = 1'b0;
`endif

    assign req_fire = (state == IDLE) && req_valid && !flush;
    assign rsp_take = !flush && bus_rsp_valid &&
                      (((state == ISSUE) && bus_rd_ready) || (state == WAIT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: defaulting every comb output first keeps uncovered branches from inferring latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_fire) state_nxt = misaligned ? HOLD : ISSUE;
            ISSUE: begin
                // A flush that loses the race with the command must still swallow its response.
                if (flush)             state_nxt = (bus_rd_ready && !bus_rsp_valid) ? DRAIN : IDLE;
                else if (bus_rd_ready) state_nxt = bus_rsp_valid ? HOLD : WAIT;
            end
            WAIT: begin
                if (flush)              state_nxt = bus_rsp_valid ? IDLE : DRAIN;
                else if (bus_rsp_valid) state_nxt = HOLD;
            end
            HOLD:  if (flush || rsp_ready) state_nxt = IDLE;
            DRAIN: if (bus_rsp_valid)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE);
        bus_rd_valid = (state == ISSUE);
        rsp_valid    = (state == HOLD);
    end

    assign bus_rd_addr = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign rsp_data    = data_q;
    assign rsp_tag     = tag_q;

    // Offset is rounded down to the size's natural alignment; dword and 32-bit word keep the full bus.
    always_comb begin
        lane_off     = addr_q[LANE_W-1:0] & ~size_mask(size_q);
        lane_shifted = bus_rsp_data >> {lane_off, 3'b000};
        lane_mask    = '1;
        lane_sign    = lane_shifted[DATA_W-1];
        case (size_q)
            2'b00: begin lane_mask = DATA_W'(64'h0000_0000_0000_00FF); lane_sign = lane_shifted[7];  end
            2'b01: begin lane_mask = DATA_W'(64'h0000_0000_0000_FFFF); lane_sign = lane_shifted[15]; end
            2'b10: begin lane_mask = DATA_W'(64'h0000_0000_FFFF_FFFF); lane_sign = lane_shifted[31]; end
            default: ;
        endcase
        lane_ext = (lane_shifted & lane_mask) | ((lane_sign && !uns_q) ? ~lane_mask : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            if (req_fire) begin
                addr_q <= req_addr;
                size_q <= req_op[1:0];
                uns_q  <= req_op[3];
                tag_q  <= req_tag;
                if (misaligned) data_q <= '0;
            end
            if (rsp_take) data_q <= lane_ext;
        end
    end

`ifdef LOAD_ALIGN_MISALIGN_EXC_EN
    logic exc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      exc_q <= 1'b0;
        else if (req_fire) exc_q <= misaligned;
    end

    assign rsp_exc = exc_q;
`else
    assign rsp_exc = 1'b0;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: 32- and 64-bit instances share stimulus, results go through a scoreboard queue.
module tb_load_align_unit;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 5;

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             exc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sel = 1'b0;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [3:0]        req_op = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              bus_rd_ready = 1'b0;
    logic              bus_rsp_valid = 1'b0;
    logic [63:0]       bus_rsp_data = '0;
    logic              rsp_ready = 1'b0;

    logic              req_valid32, req_valid64;
    logic              req_ready32, bus_rd_valid32, rsp_valid32, rsp_exc32;
    logic              req_ready64, bus_rd_valid64, rsp_valid64, rsp_exc64;
    logic [ADDR_W-1:0] bus_rd_addr32, bus_rd_addr64;
    logic [31:0]       rsp_data32;
    logic [63:0]       rsp_data64;
    logic [TAG_W-1:0]  rsp_tag32, rsp_tag64;

    logic [63:0] mon_req_ready, mon_bus_rd_valid, mon_bus_rd_addr, mon_rsp_valid;
    logic [63:0] mon_rsp_data, mon_rsp_tag, mon_rsp_exc;

    exp_t sb[$];
    exp_t exp_e;
    int   checks = 0;
    int   errors = 0;

    assign req_valid32 = req_valid && !sel;
    assign req_valid64 = req_valid && sel;

    load_align_unit #(.DATA_W(32), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid32), .req_ready(req_ready32),
        .req_addr(req_addr), .req_op(req_op), .req_tag(req_tag),
        .bus_rd_valid(bus_rd_valid32), .bus_rd_addr(bus_rd_addr32), .bus_rd_ready(bus_rd_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data[31:0]),
        .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data32), .rsp_tag(rsp_tag32), .rsp_exc(rsp_exc32)
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid64), .req_ready(req_ready64),
        .req_addr(req_addr), .req_op(req_op), .req_tag(req_tag),
        .bus_rd_valid(bus_rd_valid64), .bus_rd_addr(bus_rd_addr64), .bus_rd_ready(bus_rd_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data64), .rsp_tag(rsp_tag64), .rsp_exc(rsp_exc64)
    );

    always #5 clk = ~clk;

    always_comb begin
        mon_req_ready    = 64'(sel ? req_ready64    : req_ready32);
        mon_bus_rd_valid = 64'(sel ? bus_rd_valid64 : bus_rd_valid32);
        mon_bus_rd_addr  = 64'(sel ? bus_rd_addr64  : bus_rd_addr32);
        mon_rsp_valid    = 64'(sel ? rsp_valid64    : rsp_valid32);
        mon_rsp_data     = sel ? rsp_data64 : 64'(rsp_data32);
        mon_rsp_tag      = 64'(sel ? rsp_tag64      : rsp_tag32);
        mon_rsp_exc      = 64'(sel ? rsp_exc64      : rsp_exc32);
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every result the W stage accepts must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && mon_rsp_valid[0] && rsp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected observed tag=%0d expected=no response", mon_rsp_tag);
            end
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("rsp_data", mon_rsp_data, exp_e.data);
                check("rsp_tag", mon_rsp_tag, 64'(exp_e.tag));
                check("rsp_exc", mon_rsp_exc, 64'(exp_e.exc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fast path: accept, command taken with response in the same cycle, result 2 cycles after accept.
    task automatic do_load(input logic [31:0] addr, input logic [3:0] op, input logic [TAG_W-1:0] tag,
                           input logic [63:0] data, input logic [63:0] exp_data, input logic [31:0] exp_bus_addr);
        req_valid = 1'b1; req_addr = addr; req_op = op; req_tag = tag;
        bus_rd_ready = 1'b1; rsp_ready = 1'b1;
        sb.push_back(exp_t'{data: exp_data, tag: tag, exc: 1'b0});
        @(negedge clk);
        check("req_ready_idle", mon_req_ready, 64'd1);
        tick();
        req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = data;
        @(negedge clk);
        check("rd_valid_issue", mon_bus_rd_valid, 64'd1);
        check("rd_addr", mon_bus_rd_addr, 64'(exp_bus_addr));
        check("rsp_valid_early", mon_rsp_valid, 64'd0);
        tick();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        check("rsp_valid_lat2", mon_rsp_valid, 64'd1);
        tick();
    endtask

`ifdef LOAD_ALIGN_MISALIGN_EXC_EN
    task automatic misaligned(input logic [31:0] addr, input logic [3:0] op, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1; req_addr = addr; req_op = op; req_tag = tag;
        bus_rd_ready = 1'b1; rsp_ready = 1'b1;
        sb.push_back(exp_t'{data: 64'd0, tag: tag, exc: 1'b1});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("mis_no_rd", mon_bus_rd_valid, 64'd0);
        check("mis_hold", mon_rsp_valid, 64'd1);
        tick();
        check("mis_no_rd_after", mon_bus_rd_valid, 64'd0);
    endtask
`endif

    initial begin
        #12;
        check("rst_req_ready", mon_req_ready, 64'd1);
        check("rst_rd_valid", mon_bus_rd_valid, 64'd0);
        check("rst_rsp_valid", mon_rsp_valid, 64'd0);
        check("rst_rsp_data", mon_rsp_data, 64'd0);
        check("rst_rsp_tag", mon_rsp_tag, 64'd0);
        check("rst_rsp_exc", mon_rsp_exc, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        do_load(32'h1003, 4'b0000, 5'd7, 64'h80FF_0000, 64'hFFFF_FF80, 32'h1000);
        do_load(32'h3000, 4'b0001, 5'd4, 64'h0000_F00D, 64'hFFFF_F00D, 32'h3000);
        do_load(32'h5001, 4'b1000, 5'd5, 64'h0000_AB00, 64'h0000_00AB, 32'h5000);

        // Half unsigned through a stalled command, WAIT, then W back-pressure.
        req_valid = 1'b1; req_addr = 32'h2002; req_op = 4'b1001; req_tag = 5'd3;
        bus_rd_ready = 1'b0; rsp_ready = 1'b0;
        sb.push_back(exp_t'{data: 64'h0000_9ABC, tag: 5'd3, exc: 1'b0});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_rd_valid", mon_bus_rd_valid, 64'd1);
        check("stall_rd_addr", mon_bus_rd_addr, 64'h2000);
        check("stall_req_ready", mon_req_ready, 64'd0);
        tick();
        bus_rd_ready = 1'b1;
        tick();
        bus_rd_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h9ABC_1234;
        @(negedge clk);
        check("wait_rd_valid", mon_bus_rd_valid, 64'd0);
        check("wait_rsp_valid", mon_rsp_valid, 64'd0);
        tick();
        bus_rsp_valid = 1'b0; bus_rsp_data = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", mon_rsp_valid, 64'd1);
            check("hold_rsp_data", mon_rsp_data, 64'h0000_9ABC);
            check("hold_rsp_tag", mon_rsp_tag, 64'd3);
            check("hold_req_ready", mon_req_ready, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();

`ifdef LOAD_ALIGN_MISALIGN_EXC_EN
        misaligned(32'h1001, 4'b0010, 5'd9);
        misaligned(32'h6000, 4'b0011, 5'd10);
`else
        do_load(32'h1001, 4'b0010, 5'd9, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 32'h1000);
        do_load(32'h6000, 4'b0011, 5'd10, 64'h1234_5678, 64'h1234_5678, 32'h6000);
`endif

        // Flush together with a request in IDLE: request ignored.
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h7000; req_op = 4'b0010; req_tag = 5'd11;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("fl_idle_req_ready", mon_req_ready, 64'd1);
        check("fl_idle_rd_valid", mon_bus_rd_valid, 64'd0);
        tick();

        // Flush in ISSUE before the command handshake.
        req_valid = 1'b1; bus_rd_ready = 1'b0;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_issue_rd_valid", mon_bus_rd_valid, 64'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_issue_req_ready", mon_req_ready, 64'd1);
        check("fl_issue_rd_off", mon_bus_rd_valid, 64'd0);

        // Flush in WAIT: response two cycles later is drained silently.
        req_valid = 1'b1; bus_rd_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        bus_rd_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_wait_req_ready", mon_req_ready, 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("drain_req_ready", mon_req_ready, 64'd0);
        tick();
        bus_rsp_valid = 1'b1; bus_rsp_data = 64'h55;
        @(negedge clk);
        check("drain_rsp_valid", mon_rsp_valid, 64'd0);
        check("drain_req_ready_rsp", mon_req_ready, 64'd0);
        tick();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        check("drained_req_ready", mon_req_ready, 64'd1);
        check("drained_rsp_valid", mon_rsp_valid, 64'd0);

        // Flush in HOLD: result withdrawn next cycle.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h7004; req_tag = 5'd12; bus_rd_ready = 1'b1;
        tick();
        req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h1111_2222;
        tick();
        bus_rsp_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_hold_rsp_valid", mon_rsp_valid, 64'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_hold_dropped", mon_rsp_valid, 64'd0);
        check("fl_hold_req_ready", mon_req_ready, 64'd1);

        // Asynchronous reset while holding a result.
        req_valid = 1'b1; req_addr = 32'h7008; req_tag = 5'd13;
        tick();
        req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h3333_4444;
        tick();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_rsp_valid", mon_rsp_valid, 64'd1);
        check("pre_rst_rsp_data", mon_rsp_data, 64'h3333_4444);
        #1 reset_n = 1'b0;
        #1;
        check("arst_rsp_valid", mon_rsp_valid, 64'd0);
        check("arst_req_ready", mon_req_ready, 64'd1);
        check("arst_rsp_data", mon_rsp_data, 64'd0);
        check("arst_rsp_tag", mon_rsp_tag, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // 64-bit instance.
        sel = 1'b1;
        do_load(32'h0004, 4'b0010, 5'd14, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 32'h0000);
`ifdef LOAD_ALIGN_MISALIGN_EXC_EN
        misaligned(32'h0004, 4'b0011, 5'd15);
`else
        do_load(32'h0004, 4'b0011, 5'd15, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000, 32'h0000);
`endif
        do_load(32'h0008, 4'b0011, 5'd16, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 32'h0008);
        do_load(32'h0007, 4'b1000, 5'd17, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 32'h0000);
        do_load(32'h0006, 4'b0001, 5'd18, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 32'h0000);
        do_load(32'h0010, 4'b1010, 5'd19, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 32'h0010);

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
